// File: rtl/guess_entry_ctrl_if.sv
// Button, secret and display bundle for guess_entry_ctrl.
// master: drives buttons and secret, observes the display.
// slave:  the controller itself.
interface guess_entry_ctrl_if;
    logic       btn_inc;
    logic       btn_next;
    logic       btn_enter;
    logic [3:0] secret_0;
    logic [3:0] secret_1;
    logic [3:0] secret_2;
    logic [3:0] secret_3;
    logic [3:0] digit_0;
    logic [3:0] digit_1;
    logic [3:0] digit_2;
    logic [3:0] digit_3;
    logic [1:0] hint;
    logic [3:0] attempts_lo;
    logic [3:0] attempts_hi;
    logic       win;

    modport master (
        output btn_inc, btn_next, btn_enter,
        output secret_0, secret_1, secret_2, secret_3,
        input  digit_0, digit_1, digit_2, digit_3,
        input  hint, attempts_lo, attempts_hi, win
    );

    modport slave (
        input  btn_inc, btn_next, btn_enter,
        input  secret_0, secret_1, secret_2, secret_3,
        output digit_0, digit_1, digit_2, digit_3,
        output hint, attempts_lo, attempts_hi, win
    );
endinterface

// File: rtl/guess_entry_ctrl.sv
// Number-guessing game controller: 4-digit BCD guess entry with two buttons,
// submit/compare against a captured secret, BCD attempt counter, win display.
// Optional cursor blinking is enabled by defining the macro CURSOR_BLINK_EN.
module guess_entry_ctrl #(
    parameter int unsigned BLINK_CYCLES  = 12_500_000,
    parameter int unsigned RESULT_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    guess_entry_ctrl_if.slave bus
);

    if (BLINK_CYCLES < 2 || RESULT_CYCLES < 2) begin : g_param_check
        $error("guess_entry_ctrl: BLINK_CYCLES and RESULT_CYCLES must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTER,
        S_CHECK,
        S_RESULT,
        S_WIN
    } state_t;

    localparam int unsigned   RW          = $clog2(RESULT_CYCLES);
    localparam logic [RW-1:0] RESULT_LAST = RW'(RESULT_CYCLES - 1);

    state_t              state_q;
    logic [3:0][3:0]     secret_q;
    logic [3:0][3:0]     guess_q;
    logic [1:0]          cursor_q;
    logic [7:0]          attempts_q;
    logic [1:0]          hint_q;
    logic [RW-1:0]       res_cnt_q;

    logic [2:0]          btn_s_q;   // {enter, next, inc} sampled
    logic [2:0]          btn_p_q;   // previous sample
    logic [2:0]          rise;
    logic                enter_ev, next_ev, inc_ev;

    logic [7:0]          attempts_d;
    logic [1:0]          hint_d;
    logic [3:0][3:0]     disp_d;

`ifdef CURSOR_BLINK_EN
    localparam int unsigned   BW         = $clog2(BLINK_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    logic [BW-1:0]       blink_cnt_q;
    logic                blink_q;
`endif

    // Button sampling; both stages reset high so a button held through reset release never fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s_q <= '1;
            btn_p_q <= '1;
        end else begin
            btn_s_q <= {bus.btn_enter, bus.btn_next, bus.btn_inc};
            btn_p_q <= btn_s_q;
        end
    end

    assign rise     = btn_s_q & ~btn_p_q;
    assign enter_ev = rise[2];
    assign next_ev  = rise[1] & ~rise[2];
    assign inc_ev   = rise[0] & ~rise[1] & ~rise[2];

    // Next attempt count, comparison result and display digits.
    always_comb begin
        attempts_d = attempts_q;
        if (attempts_q != 8'h99) begin
            if (attempts_q[3:0] == 4'd9) attempts_d = {attempts_q[7:4] + 4'd1, 4'd0};
            else                         attempts_d = {attempts_q[7:4], attempts_q[3:0] + 4'd1};
        end

        // BCD digits are all <= 9, so comparing the packed nibbles orders them numerically
        if (guess_q == secret_q)     hint_d = 2'b11;
        else if (guess_q > secret_q) hint_d = 2'b01;
        else                         hint_d = 2'b10;

        disp_d = '1;
        for (int unsigned n = 0; n < 4; n++) begin
            disp_d[n] = (state_q == S_IDLE) ? 4'hF : guess_q[n];
`ifdef CURSOR_BLINK_EN
            if (state_q == S_ENTER && blink_q && cursor_q == 2'(n)) disp_d[n] = 4'hF;
`endif
        end
    end

    // Game FSM together with guess, cursor, attempts, hint and blink state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            secret_q    <= '0;
            guess_q     <= '0;
            cursor_q    <= 2'd3;
            attempts_q  <= '0;
            hint_q      <= '0;
            res_cnt_q   <= '0;
`ifdef CURSOR_BLINK_EN
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enter_ev) begin
                        secret_q[0] <= (bus.secret_0 > 4'd9) ? 4'd9 : bus.secret_0;
                        secret_q[1] <= (bus.secret_1 > 4'd9) ? 4'd9 : bus.secret_1;
                        secret_q[2] <= (bus.secret_2 > 4'd9) ? 4'd9 : bus.secret_2;
                        secret_q[3] <= (bus.secret_3 > 4'd9) ? 4'd9 : bus.secret_3;
                        guess_q     <= '0;
                        cursor_q    <= 2'd3;
                        attempts_q  <= '0;
                        hint_q      <= '0;
                        state_q     <= S_ENTER;
                    end
                end
                S_ENTER: begin
                    if (enter_ev) begin
                        state_q <= S_CHECK;
                    end else if (next_ev) begin
                        cursor_q <= cursor_q - 2'd1;
                    end else if (inc_ev) begin
                        guess_q[cursor_q] <= (guess_q[cursor_q] >= 4'd9) ? 4'd0
                                                                         : guess_q[cursor_q] + 4'd1;
                    end
                end
                S_CHECK: begin
                    hint_q     <= hint_d;
                    attempts_q <= attempts_d;
                    res_cnt_q  <= '0;
                    state_q    <= (hint_d == 2'b11) ? S_WIN : S_RESULT;
                end
                S_RESULT: begin
                    if (res_cnt_q == RESULT_LAST) begin
                        hint_q  <= '0;
                        state_q <= S_ENTER;
                    end else begin
                        res_cnt_q <= res_cnt_q + 1'b1;
                    end
                end
                S_WIN: begin
                    if (enter_ev) begin
                        hint_q  <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

`ifdef CURSOR_BLINK_EN
            // held at zero outside ENTER, so every entry into ENTER starts a fresh visible phase
            if (state_q != S_ENTER || inc_ev || next_ev) begin
                blink_cnt_q <= '0;
                blink_q     <= 1'b0;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
`endif
        end
    end

    // Output registers, one cycle behind the state they reflect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.digit_0     <= 4'hF;
            bus.digit_1     <= 4'hF;
            bus.digit_2     <= 4'hF;
            bus.digit_3     <= 4'hF;
            bus.hint        <= '0;
            bus.attempts_lo <= '0;
            bus.attempts_hi <= '0;
            bus.win         <= 1'b0;
        end else begin
            bus.digit_0     <= disp_d[0];
            bus.digit_1     <= disp_d[1];
            bus.digit_2     <= disp_d[2];
            bus.digit_3     <= disp_d[3];
            bus.hint        <= hint_q;
            bus.attempts_lo <= attempts_q[3:0];
            bus.attempts_hi <= attempts_q[7:4];
            bus.win         <= (state_q == S_WIN);
        end
    end

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Directed bench for guess_entry_ctrl (BLINK_CYCLES=4, RESULT_CYCLES=6).
module tb_guess_entry_ctrl;

    localparam int A_NONE  = 0;
    localparam int A_INC   = 1;
    localparam int A_NEXT  = 2;
    localparam int A_ENTER = 3;
    localparam int A_BOTH  = 4;  // enter + inc together
    localparam int A_NI    = 5;  // next + inc together
    localparam int A_WAIT  = 6;  // idle cycles

    typedef struct {
        int         act;
        int         reps;
        logic [15:0] dig;
        logic [1:0] hint;
        logic [7:0] att;
        logic       win;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    vec_t vecs[$];

    guess_entry_ctrl_if bus ();

    guess_entry_ctrl #(
        .BLINK_CYCLES  (4),
        .RESULT_CYCLES (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [15:0] digits();
        return {bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0};
    endfunction

    task automatic set_btns(input int act, input logic v);
        case (act)
            A_INC:   bus.btn_inc = v;
            A_NEXT:  bus.btn_next = v;
            A_ENTER: bus.btn_enter = v;
            A_BOTH:  begin bus.btn_enter = v; bus.btn_inc = v; end
            A_NI:    begin bus.btn_next = v; bus.btn_inc = v; end
            default: ;
        endcase
    endtask

    // Called at a falling edge; returns at the falling edge where the button is released.
    task automatic press(input int act);
        set_btns(act, 1'b1);
        @(negedge clk);
        @(negedge clk);
        set_btns(act, 1'b0);
    endtask

    // Press and let the effect reach the registered outputs.
    task automatic press_settle(input int act);
        press(act);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int          cnt;
        logic [3:0]  expd;

        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.btn_inc = 1'b0; bus.btn_next = 1'b0; bus.btn_enter = 1'b0;
        bus.secret_3 = 4'd1; bus.secret_2 = 4'd2; bus.secret_1 = 4'd3; bus.secret_0 = 4'd4;

        //            act      reps  digits    hint   att    win
        vecs.push_back('{A_NONE,  0, 16'hFFFF, 2'b00, 8'h00, 1'b0});
        vecs.push_back('{A_ENTER, 1, 16'h0000, 2'b00, 8'h00, 1'b0});
        vecs.push_back('{A_INC,   9, 16'h9000, 2'b00, 8'h00, 1'b0});
        vecs.push_back('{A_INC,   2, 16'h1000, 2'b00, 8'h00, 1'b0});
        vecs.push_back('{A_INC,   4, 16'h5000, 2'b00, 8'h00, 1'b0});
        vecs.push_back('{A_ENTER, 1, 16'h5000, 2'b01, 8'h01, 1'b0});
        vecs.push_back('{A_WAIT,  8, 16'h5000, 2'b00, 8'h01, 1'b0});
        vecs.push_back('{A_INC,   6, 16'h1000, 2'b00, 8'h01, 1'b0});
        vecs.push_back('{A_NEXT,  1, 16'h1000, 2'b00, 8'h01, 1'b0});
        vecs.push_back('{A_INC,   2, 16'h1200, 2'b00, 8'h01, 1'b0});
        vecs.push_back('{A_NEXT,  1, 16'h1200, 2'b00, 8'h01, 1'b0});
        vecs.push_back('{A_INC,   3, 16'h1230, 2'b00, 8'h01, 1'b0});
        vecs.push_back('{A_NEXT,  1, 16'h1230, 2'b00, 8'h01, 1'b0});
        vecs.push_back('{A_INC,   4, 16'h1234, 2'b00, 8'h01, 1'b0});
        vecs.push_back('{A_NEXT,  1, 16'h1234, 2'b00, 8'h01, 1'b0});
        vecs.push_back('{A_INC,   1, 16'h2234, 2'b00, 8'h01, 1'b0});
        vecs.push_back('{A_INC,   9, 16'h1234, 2'b00, 8'h01, 1'b0});
        vecs.push_back('{A_ENTER, 1, 16'h1234, 2'b11, 8'h02, 1'b1});
        vecs.push_back('{A_WAIT,  8, 16'h1234, 2'b11, 8'h02, 1'b1});
        vecs.push_back('{A_INC,   1, 16'h1234, 2'b11, 8'h02, 1'b1});
        vecs.push_back('{A_NEXT,  1, 16'h1234, 2'b11, 8'h02, 1'b1});
        vecs.push_back('{A_ENTER, 1, 16'hFFFF, 2'b00, 8'h02, 1'b0});
        vecs.push_back('{A_BOTH,  1, 16'h0000, 2'b00, 8'h00, 1'b0});
        vecs.push_back('{A_BOTH,  1, 16'h0000, 2'b10, 8'h01, 1'b0});
        vecs.push_back('{A_WAIT,  8, 16'h0000, 2'b00, 8'h01, 1'b0});
        vecs.push_back('{A_NI,    1, 16'h0000, 2'b00, 8'h01, 1'b0});
        vecs.push_back('{A_INC,   1, 16'h0100, 2'b00, 8'h01, 1'b0});

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].act == A_WAIT) repeat (vecs[i].reps) @(negedge clk);
            else repeat (vecs[i].reps) press_settle(vecs[i].act);
            check($sformatf("row%0d digits", i), 32'(digits()), 32'(vecs[i].dig));
            check($sformatf("row%0d hint", i), 32'(bus.hint), 32'(vecs[i].hint));
            check($sformatf("row%0d attempts", i), 32'({bus.attempts_hi, bus.attempts_lo}), 32'(vecs[i].att));
            check($sformatf("row%0d win", i), 32'(bus.win), 32'(vecs[i].win));
        end

        // Cursor (digit 2) right after an accepted inc: 4 cycles shown, 4 blanked, repeating.
        press(A_INC);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
`ifdef CURSOR_BLINK_EN
            expd = (((k / 4) % 2) == 1) ? 4'hF : 4'd2;
`else
            expd = 4'd2;
`endif
            check($sformatf("blink k%0d cursor", k), 32'(bus.digit_2), 32'(expd));
            check($sformatf("blink k%0d other", k), 32'(bus.digit_3), 32'h0);
        end

        // Guess 5200 (too high): hint held for exactly RESULT_CYCLES, guess kept afterwards.
        repeat (3) press_settle(A_NEXT);
        repeat (5) press_settle(A_INC);
        press(A_ENTER);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.hint == 2'b01) cnt++;
        end
        check("result hint cycles", 32'(cnt), 32'd6);
        check("result hint cleared", 32'(bus.hint), 32'h0);
        check("result attempts", 32'({bus.attempts_hi, bus.attempts_lo}), 32'h02);
        press_settle(A_INC);
        check("guess kept after result", 32'(digits()), 32'h6200);

        // Wrong guesses 3..99 with the BCD tens carry and saturation checked on the way.
        for (int g = 3; g <= 99; g++) begin
            press_settle(A_ENTER);
            if (g == 10) check("attempts carry", 32'({bus.attempts_hi, bus.attempts_lo}), 32'h10);
            if (g == 99) check("attempts at 99", 32'({bus.attempts_hi, bus.attempts_lo}), 32'h99);
            repeat (8) @(negedge clk);
        end
        press_settle(A_ENTER);
        check("attempts saturated", 32'({bus.attempts_hi, bus.attempts_lo}), 32'h99);
        check("hint mid result", 32'(bus.hint), 32'h1);

        // Reset in the middle of RESULT clears outputs without waiting for a clock.
        rst_n = 1'b0;
        #1;
        check("reset digits", 32'(digits()), 32'hFFFF);
        check("reset hint", 32'(bus.hint), 32'h0);
        check("reset attempts", 32'({bus.attempts_hi, bus.attempts_lo}), 32'h00);
        check("reset win", 32'(bus.win), 32'h0);

        // Enter held through reset release must not start a game.
        bus.btn_enter = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("held enter ignored", 32'(digits()), 32'hFFFF);
        bus.btn_enter = 1'b0;
        repeat (2) @(negedge clk);

        // Secret digit 0xA is clamped to 9, so guess 0009 wins.
        bus.secret_3 = 4'd0; bus.secret_2 = 4'd0; bus.secret_1 = 4'd0; bus.secret_0 = 4'hA;
        press_settle(A_ENTER);
        check("new game digits", 32'(digits()), 32'h0000);
        repeat (3) press_settle(A_NEXT);
        repeat (9) press_settle(A_INC);
        check("clamp guess", 32'(digits()), 32'h0009);
        press_settle(A_ENTER);
        check("clamp hint", 32'(bus.hint), 32'h3);
        check("clamp win", 32'(bus.win), 32'h1);
        check("clamp attempts", 32'({bus.attempts_hi, bus.attempts_lo}), 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/guess_entry_ctrl.md
GUESS_ENTRY_CTRL -- requirements
Module: guess_entry_ctrl

Interface
REQ-001 Parameter BLINK_CYCLES, default 12_500_000: clock cycles per cursor blink half-period (>=2).
REQ-002 Parameter RESULT_CYCLES, default 50_000_000: clock cycles the hint is held after a check (>=2).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 btn_inc  input  1  level, debounced: increment selected digit.
REQ-006 btn_next  input  1  level, debounced: move cursor to next lower digit.
REQ-007 btn_enter  input  1  level, debounced: start game / submit guess / restart.
REQ-008 secret_0..secret_3  input  4 each  BCD secret digits; secret_3 is the most significant digit.
REQ-009 digit_0..digit_3  output  4 each  registered BCD digits for the 7-segment decoder; 4'hF means blank.
REQ-010 hint  output  2  registered: 00 none, 01 guess too high, 10 guess too low, 11 equal.
REQ-011 attempts_lo, attempts_hi  output  4 each  registered BCD attempt count, units and tens.
REQ-012 win  output  1  registered; high while in WIN.

Function
REQ-013 Each btn_* shall pass through one sampling register; an action fires on a 0->1 edge only, once per press.
REQ-014 Simultaneous edges shall resolve by priority enter > next > inc; lower-priority edges in the same cycle are dropped.
REQ-015 FSM states shall be IDLE, ENTER, CHECK, RESULT, WIN.
REQ-016 IDLE: all digit_n shall be 4'hF; an enter edge captures secret_0..3, clears guess to 0000, cursor to 3, attempts to 00, hint to 00, and moves to ENTER.
REQ-017 A captured secret digit >9 shall be clamped to 9.
REQ-018 ENTER: an inc edge advances the guess digit at the cursor 0..9, wrapping 9->0.
REQ-019 ENTER: a next edge moves the cursor 3->2->1->0->3.
REQ-020 ENTER: an enter edge moves to CHECK.
REQ-021 CHECK: lasts exactly one cycle. It compares guess and secret as 4-digit decimal numbers and sets hint. It increments attempts in BCD, saturating at 99. It goes to WIN if equal, else RESULT.
REQ-022 RESULT: holds hint for RESULT_CYCLES cycles, then clears hint to 00, returns to ENTER, and keeps guess and cursor.
REQ-023 In CHECK and RESULT all button edges shall be ignored.
REQ-024 WIN: hint stays 11, win=1, and the guess is displayed; an enter edge goes to IDLE; inc and next are ignored.
REQ-025 In ENTER, CHECK, RESULT and WIN, digit_n shall equal the guess digit n, subject to REQ-030.
REQ-026 All outputs shall update one cycle after the state or register change that causes them.

Reset
REQ-027 While rst_n=0, the block shall be in IDLE with digit_0..3=4'hF, hint=00, attempts=00, win=0, guess=0000, cursor=3, and blink phase=0.
REQ-028 Reset asserted mid-game shall abort immediately; the captured secret is discarded.
REQ-029 After release, edge detection shall not fire for a button already held high at release.

Configuration
REQ-030 With macro CURSOR_BLINK_EN defined, in ENTER only, the cursor digit shall output 4'hF while blink phase=1.
  - Blink phase toggles every BLINK_CYCLES cycles.
  - The blink counter and phase reset to 0 on any accepted inc or next edge and on entry to ENTER.
REQ-031 Without CURSOR_BLINK_EN, the blink counter and phase logic shall be absent and the cursor digit shall never be blanked.

Verification
REQ-032 Reset, then enter with secret 1,2,3,4 (digit_3..0) -> ENTER, digit_3..0 = 0,0,0,0, cursor 3, attempts 00.
REQ-033 From ENTER: inc x11 on the cursor digit -> digit_3=1 (wrap 9->0), other digits unchanged.
REQ-034 Enter guess 5000 against secret 1234 -> hint=01 for RESULT_CYCLES cycles, attempts_lo=1, then hint=00 and back in ENTER with guess 5000.
REQ-035 Enter guess 1234 -> hint=11, win=1; next enter -> IDLE with digits all 4'hF; enter and inc in the same cycle -> only enter acts.
REQ-036 Submit 100 wrong guesses -> attempts saturates at 99; assert rst_n=0 mid-RESULT -> all REQ-027 values at once.
REQ-037 With CURSOR_BLINK_EN and BLINK_CYCLES=4, in ENTER idle -> cursor digit alternates value/4'hF every 4 cycles; without the macro -> constant value.
